// File: rtl/vram_scanout.sv
// 640x480@60 scanout reader for a 320x240 RGB565 frame buffer, each source pixel doubled in x and y.
// Optional colour-bar generator on a test_pattern input when VRAM_SCANOUT_TESTPATTERN_EN is defined.
module vram_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned FB_WIDTH = 320
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [16:0] vram_address_p2,
    output logic        vram_writeEnable_p2,
    output logic [15:0] vram_dataIn_p2,
    input  logic [15:0] vram_dataOut_p2,
`ifdef VRAM_SCANOUT_TESTPATTERN_EN
    input  logic        test_pattern,
`endif
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [4:0]  red,
    output logic [5:0]  green,
    output logic [4:0]  blue,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  h_q, h_d, v_q, v_d;
    logic [16:0] line_base_q, line_base_d;
    logic        active, hs_raw, vs_raw, first;

    // Counter-time state
    always_comb begin
        h_d         = h_q + 10'd1;
        v_d         = v_q;
        line_base_d = line_base_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d         = '0;
                line_base_d = '0;
            end else begin
                v_d = v_q + 10'd1;
                // Advance the source line after the second copy of each line
                if (v_q[0] && (v_q < 10'(V_ACTIVE - 1))) begin
                    line_base_d = line_base_q + 17'(FB_WIDTH);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_q         <= '0;
            v_q         <= '0;
            line_base_q <= '0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            line_base_q <= line_base_d;
        end
    end

    always_comb begin
        active          = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
        hs_raw          = (h_q >= HS_START) && (h_q < HS_END);
        vs_raw          = (v_q >= VS_START) && (v_q < VS_END);
        first           = (h_q == '0) && (v_q == '0);
        vram_address_p2 = active ? (line_base_q + 17'(h_q[9:1])) : '0;
    end

    assign vram_writeEnable_p2 = 1'b0;
    assign vram_dataIn_p2      = '0;

    // Stage 1: timing flags aligned with the read data arriving next cycle
    logic        act1_q, hs1_q, vs1_q, first1_q;
    logic [15:0] pix;

`ifdef VRAM_SCANOUT_TESTPATTERN_EN
    localparam int unsigned BAR_W = H_ACTIVE / 8;
    logic [2:0] bar_d, bar1_q;

    always_comb begin
        bar_d = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (h_q >= 10'(k * BAR_W)) bar_d = 3'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) bar1_q <= '0;
        else          bar1_q <= bar_d;
    end

    always_comb begin
        pix = vram_dataOut_p2;
        if (test_pattern) begin
            unique case (bar1_q)
                3'd0:    pix = 16'hFFFF;
                3'd1:    pix = 16'hFFE0;
                3'd2:    pix = 16'h07FF;
                3'd3:    pix = 16'h07E0;
                3'd4:    pix = 16'hF81F;
                3'd5:    pix = 16'hF800;
                3'd6:    pix = 16'h001F;
                default: pix = 16'h0000;
            endcase
        end
    end
`else
    assign pix = vram_dataOut_p2;
`endif

    logic        de_q, hsync_q, vsync_q, fs_q;
    logic [15:0] rgb_q, rgb_d;

    assign rgb_d = act1_q ? pix : 16'h0000;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            act1_q   <= 1'b0;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            first1_q <= 1'b0;
            de_q     <= 1'b0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            fs_q     <= 1'b0;
            rgb_q    <= '0;
        end else begin
            act1_q   <= active;
            hs1_q    <= hs_raw;
            vs1_q    <= vs_raw;
            first1_q <= first;
            de_q     <= act1_q;
            hsync_q  <= ~hs1_q;
            vsync_q  <= ~vs1_q;
            fs_q     <= first1_q;
            rgb_q    <= rgb_d;
        end
    end

    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;
    assign red         = rgb_q[15:11];
    assign green       = rgb_q[10:5];
    assign blue        = rgb_q[4:0];

endmodule
